// File: rtl/sync_fifo_ctrl.sv
// Fire-driven micro-pipeline FIFO controller with an output-delay line on the last stage.
// Optional status outputs (o_count, o_err) are built when SYNC_FIFO_CTRL_STATUS_EN is defined.
module sync_fifo_ctrl #(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned OUT_DLY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_drive,
    output logic                         o_free,
    output logic                         o_ready,
    output logic                         o_driveNext,
    input  logic                         i_freeNext,
`ifdef SYNC_FIFO_CTRL_STATUS_EN
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err,
`endif
    output logic [DEPTH-1:0]             o_fire_n
);

    logic [DEPTH-1:0]   v;
    logic [DEPTH-1:0]   v_nxt;
    logic [DEPTH-1:0]   fire_nxt;
    logic               sent;
    logic               sent_nxt;
    logic [OUT_DLY-1:0] dl;
    logic [OUT_DLY-1:0] dl_nxt;
    logic               free_nxt;
    logic               accept;

    assign o_ready = !v[0];
    assign accept  = i_freeNext && v[DEPTH-1] && sent;

    // Token movement: every stage decides from registered occupancy only.
    always_comb begin
        v_nxt    = v;
        fire_nxt = '0;
        free_nxt = v[0] && !v[1];
        if (i_drive && !v[0]) begin
            v_nxt[0]    = 1'b1;
            fire_nxt[0] = 1'b1;
        end
        for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            if (v[k] && !v[k+1]) begin
                v_nxt[k]      = 1'b0;
                v_nxt[k+1]    = 1'b1;
                fire_nxt[k+1] = 1'b1;
            end
        end
        if (accept) begin
            v_nxt[DEPTH-1] = 1'b0;
        end
    end

    // Delay line is fed with the next-cycle last-stage fire so its tail lines up with o_driveNext.
    always_comb begin
        dl_nxt    = dl << 1;
        dl_nxt[0] = fire_nxt[DEPTH-1];
        sent_nxt  = sent;
        if (dl[OUT_DLY-1]) begin
            sent_nxt = 1'b1;
        end
        if (accept) begin
            sent_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v           <= '0;
            sent        <= 1'b0;
            dl          <= '0;
            o_fire_n    <= '0;
            o_free      <= 1'b0;
            o_driveNext <= 1'b0;
        end else begin
            v           <= v_nxt;
            sent        <= sent_nxt;
            dl          <= dl_nxt;
            o_fire_n    <= fire_nxt;
            o_free      <= free_nxt;
            o_driveNext <= dl[OUT_DLY-1];
        end
    end

`ifdef SYNC_FIFO_CTRL_STATUS_EN
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count_nxt;
    logic             err_nxt;

    // Count tracks the occupancy being registered; error is sticky until reset.
    always_comb begin
        count_nxt = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count_nxt = count_nxt + CNT_W'(v_nxt[k]);
        end
        err_nxt = o_err || (i_drive && v[0]) || (i_freeNext && !accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_count <= '0;
            o_err   <= 1'b0;
        end else begin
            o_count <= count_nxt;
            o_err   <= err_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: DEPTH=3/OUT_DLY=2 main instance plus 2/1 and 8/4 sweep instances.
// Status outputs are checked when SYNC_FIFO_CTRL_STATUS_EN is defined.
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv0 = 1'b0, fn0 = 1'b0, free0, rdy0, dn0;
    logic [2:0] fire0;
    logic       drv1 = 1'b0, fn1 = 1'b0, free1, rdy1, dn1;
    logic [1:0] fire1;
    logic       drv2 = 1'b0, fn2 = 1'b0, free2, rdy2, dn2;
    logic [7:0] fire2;
`ifdef SYNC_FIFO_CTRL_STATUS_EN
    logic [1:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic       err0, err1, err2;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int dn0_q[$], dn1_q[$], dn2_q[$], f0_q[$], exp_q[$];
    int fire00_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: log pulse cycles mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (dn0) dn0_q.push_back(cyc);
        if (dn1) dn1_q.push_back(cyc);
        if (dn2) dn2_q.push_back(cyc);
        if (fire2[0]) f0_q.push_back(cyc);
        if (fire0[0]) fire00_cnt++;
    end

    sync_fifo_ctrl #(.DEPTH(3), .OUT_DLY(2)) u0 (
        .clk(clk), .rst(rst), .i_drive(drv0), .o_free(free0), .o_ready(rdy0),
        .o_driveNext(dn0), .i_freeNext(fn0),
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        .o_count(cnt0), .o_err(err0),
`endif
        .o_fire_n(fire0)
    );

    sync_fifo_ctrl #(.DEPTH(2), .OUT_DLY(1)) u1 (
        .clk(clk), .rst(rst), .i_drive(drv1), .o_free(free1), .o_ready(rdy1),
        .o_driveNext(dn1), .i_freeNext(fn1),
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        .o_count(cnt1), .o_err(err1),
`endif
        .o_fire_n(fire1)
    );

    sync_fifo_ctrl #(.DEPTH(8), .OUT_DLY(4)) u2 (
        .clk(clk), .rst(rst), .i_drive(drv2), .o_free(free2), .o_ready(rdy2),
        .o_driveNext(dn2), .i_freeNext(fn2),
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        .o_count(cnt2), .o_err(err2),
`endif
        .o_fire_n(fire2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        drv0 = 1'b0; fn0 = 1'b0; drv1 = 1'b0; fn1 = 1'b0; drv2 = 1'b0; fn2 = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        dn0_q.delete(); dn1_q.delete(); dn2_q.delete(); f0_q.delete(); exp_q.delete();
        fire00_cnt = 0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1;
        tick(2);
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        obs = {fire0, free0, dn0, rdy0};
        total++; if (obs !== 6'b000001) $display("FAIL reset_hold got=%b exp=000001", obs); else passed++;
        rst = 1'b0;
        tick(1);
        obs = {fire0, free0, dn0, rdy0};
        total++; if (obs !== 6'b000001) $display("FAIL reset_release got=%b exp=000001", obs); else passed++;
        total++; if ({rdy1, rdy2, dn1, dn2} !== 4'b1100) $display("FAIL reset_sweep got=%b exp=1100", {rdy1, rdy2, dn1, dn2}); else passed++;
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if ({cnt0, err0} !== 3'b000) $display("FAIL reset_status got=%b exp=000", {cnt0, err0}); else passed++;
`endif
    endtask

    task automatic test_single_token();
        logic [5:0] obs, expv;
        int t0;
        apply_reset();
        t0 = cyc;
        exp_q.push_back(6'b001000); exp_q.push_back(6'b010101);
        exp_q.push_back(6'b100001); exp_q.push_back(6'b000001);
        exp_q.push_back(6'b000011); exp_q.push_back(6'b000001);
        exp_q.push_back(6'b000001); exp_q.push_back(6'b000001);
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            obs  = {fire0, free0, dn0, rdy0};
            expv = 6'(exp_q.pop_front());
            total++; if (obs !== expv) $display("FAIL single_c%0d got=%b exp=%b", i, obs, expv); else passed++;
            if (i == 7) fn0 = 1'b1;
            if (i < 8) tick(1);
            fn0 = 1'b0;
        end
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if (cnt0 !== 2'd0) $display("FAIL single_empty_count got=%0d exp=0", cnt0); else passed++;
`endif
        // A follow-up token must pass straight through if the last stage really emptied.
        t0 = cyc;
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        tick(6);
        total++; if (dn0_q.size() != 2 || dn0_q[1] != t0 + 5) $display("FAIL single_refill got=%0d pulses exp=2, last at %0d", dn0_q.size(), t0 + 5); else passed++;
    endtask

    task automatic test_fill();
        int accepted = 0;
        int got;
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            int w = 0;
            while (!rdy0 && w < 12) begin
                tick(1);
                w++;
            end
            if (rdy0) begin
                if (accepted == 0) exp_q.push_back(cyc + 5);
                drv0 = 1'b1;
                tick(1);
                drv0 = 1'b0;
                accepted++;
            end
        end
        tick(10);
        total++; if (accepted != 3) $display("FAIL fill_accepted got=%0d exp=3", accepted); else passed++;
        total++; if (fire00_cnt != 3) $display("FAIL fill_stage0_fires got=%0d exp=3", fire00_cnt); else passed++;
        total++; if (rdy0 !== 1'b0) $display("FAIL fill_ready got=%b exp=0", rdy0); else passed++;
        total++; if (dn0_q.size() != 1) $display("FAIL fill_dn_once got=%0d exp=1", dn0_q.size()); else passed++;
        got = (dn0_q.size() != 0) ? dn0_q[0] : -1;
        total++; if (got != exp_q[0]) $display("FAIL fill_dn_cycle got=%0d exp=%0d", got, exp_q[0]); else passed++;
        dn0_q.delete(); exp_q.delete();
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if ({cnt0, err0} !== 3'b110) $display("FAIL fill_status got=%b exp=110", {cnt0, err0}); else passed++;
`endif
    endtask

    task automatic test_drop_full();
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        total++; if (fire0 !== 3'b000) $display("FAIL drop_no_fire got=%b exp=000", fire0); else passed++;
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if ({cnt0, err0} !== 3'b111) $display("FAIL drop_status got=%b exp=111", {cnt0, err0}); else passed++;
`endif
        tick(3);
        total++; if (fire00_cnt != 3 || rdy0 !== 1'b0) $display("FAIL drop_hold got=%0d fires ready=%b exp=3 fires ready=0", fire00_cnt, rdy0); else passed++;
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if (err0 !== 1'b1) $display("FAIL drop_err_sticky got=%b exp=1", err0); else passed++;
`endif
    endtask

    task automatic test_free_after_full();
        int got;
        exp_q.push_back(cyc + 4);
        fn0 = 1'b1;
        tick(1);
        fn0 = 1'b0;
        tick(8);
        total++; if (dn0_q.size() != 1) $display("FAIL refree_dn_count got=%0d exp=1", dn0_q.size()); else passed++;
        got = (dn0_q.size() != 0) ? dn0_q[0] : -1;
        total++; if (got != exp_q[0]) $display("FAIL refree_dn_cycle got=%0d exp=%0d", got, exp_q[0]); else passed++;
    endtask

    task automatic test_spurious_free();
        logic [5:0] obs;
        apply_reset();
        fn0 = 1'b1;
        tick(1);
        fn0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {fire0, free0, dn0, rdy0};
            total++; if (obs !== 6'b000001) $display("FAIL spurious_c%0d got=%b exp=000001", i, obs); else passed++;
            tick(1);
        end
`ifdef SYNC_FIFO_CTRL_STATUS_EN
        total++; if ({cnt0, err0} !== 3'b001) $display("FAIL spurious_status got=%b exp=001", {cnt0, err0}); else passed++;
`endif
    endtask

    task automatic test_early_free();
        int t0;
        apply_reset();
        t0 = cyc;
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        tick(2);
        // Token sits in the last stage but has not been offered downstream yet.
        fn0 = 1'b1;
        tick(1);
        fn0 = 1'b0;
        tick(3);
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        tick(12);
        total++; if (dn0_q.size() != 1 || dn0_q[0] != t0 + 5) $display("FAIL early_free_ignored got=%0d pulses exp=1 at %0d", dn0_q.size(), t0 + 5); else passed++;
    endtask

    task automatic test_reset_midflight();
        logic [5:0] obs;
        apply_reset();
        drv0 = 1'b1;
        tick(1);
        drv0 = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        obs = {fire0, free0, dn0, rdy0};
        total++; if (obs !== 6'b000001) $display("FAIL midflight_clear got=%b exp=000001", obs); else passed++;
        tick(10);
        total++; if (dn0_q.size() != 0) $display("FAIL midflight_no_dn got=%0d exp=0", dn0_q.size()); else passed++;
    endtask

    task automatic test_param_sweep();
        int t1, t2, got;
        apply_reset();
        t1 = cyc;
        t2 = cyc;
        drv1 = 1'b1;
        drv2 = 1'b1;
        tick(1);
        drv1 = 1'b0;
        drv2 = 1'b0;
        tick(15);
        got = (dn1_q.size() != 0) ? dn1_q[0] - t1 : -1;
        total++; if (got != 3) $display("FAIL sweep_d2_latency got=%0d exp=3", got); else passed++;
        got = (dn2_q.size() != 0) ? dn2_q[0] - t2 : -1;
        total++; if (got != 12) $display("FAIL sweep_d8_latency got=%0d exp=12", got); else passed++;
    endtask

    task automatic test_back_to_back();
        int c0 = -1;
        int got, expc;
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            int w = 0;
            while (!rdy2 && w < 8) begin
                tick(1);
                w++;
            end
            if (rdy2) begin
                if (c0 < 0) c0 = cyc;
                exp_q.push_back(c0 + 1 + 2 * n);
                drv2 = 1'b1;
                tick(1);
                drv2 = 1'b0;
            end
        end
        tick(4);
        for (int n = 0; n < 5; n++) begin
            expc = (exp_q.size() != 0) ? exp_q.pop_front() : -2;
            if (f0_q.size() != 0) got = f0_q.pop_front();
            else got = -1;
            total++; if (got != expc) $display("FAIL b2b_fire0_%0d got=%0d exp=%0d", n, got, expc); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single_token();
        test_fill();
        test_drop_full();
        test_free_after_full();
        test_spurious_free();
        test_early_free();
        test_reset_midflight();
        test_param_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
